mp_sequencer: RTL and testbench
===============================

# mp_sequencer

Multicycle control sequencer for the course microprocessor. It steps the shared datapath (PC, IR, register file, ALU, unified memory port) through fetch/decode/execute/memory/write-back, drives every datapath enable, and handles the memory request/acknowledge handshake with a stall timeout. It sits between the top-level `Test` wrapper and the datapath; the 7-segment display path is unaffected.

## Interface
- MEM_WAIT_MAX, default 15: maximum consecutive cycles one memory request may wait for `mem_ack` before FAULT; legal range 1..255.
- clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- instr  in  8  current IR contents from the datapath; fields are op=[7:6], rs=[5:4], rt=[3:2], rd=[1:0], imm=[1:0], joff=[5:0].
- mem_ack  in  1  memory acknowledge; read data is valid in the same cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write qualifier for `mem_req`.
- ir_load  out  1  load the IR from memory read data.
- pc_inc  out  1  PC <= PC+1.
- pc_jump  out  1  PC <= PC + sign-extended joff.
- reg_we  out  1  register file write enable.
- wb_sel  out  1  write-back source: 0 = ALU, 1 = memory data.
- alu_b_sel  out  1  ALU B operand: 0 = rt, 1 = sign-extended imm.
- state  out  3  current state code.
- halted  out  1  high in HALT or FAULT.
- err  out  1  high in FAULT only.
- instr_count  out  16  retired-instruction counter.

## Operation
- Opcodes: 00 ADD rd=rs+rt; 01 LW rt=M[rs+imm]; 10 SW M[rs+imm]=rt; 11 JMP PC+=joff. Exception: `instr==8'hC0` (JMP 0) is HALT.
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6. Code 7 is unreachable and must go to FETCH.
- FETCH:
  - Drive `mem_req=1`, `mem_we=0`.
  - When `mem_ack=1`: pulse `ir_load` and `pc_inc` in that same cycle, then go to DECODE.
- DECODE (1 cycle):
  - op 00/01/10: go to EXEC.
  - op 11 with joff≠0: assert `pc_jump`, retire, go to FETCH.
  - HALT encoding: retire, go to HALT.
- EXEC (1 cycle): `alu_b_sel = (op≠00)`. ADD goes to WB; LW/SW go to MEM.
- MEM:
  - Drive `mem_req=1`, `alu_b_sel=1`, `mem_we=(op==10)`.
  - On `mem_ack`: SW retires and goes to FETCH; LW goes to WB.
- WB (1 cycle): `reg_we=1`, `wb_sel=(op==01)`, retire, go to FETCH.
- HALT: sticky; `halted=1`. Only Reset exits.
- FAULT: sticky; `halted=1`, `err=1`. Only Reset exits.
- Retire means `instr_count` increments by 1 on the next edge. The count wraps 16'hFFFF→0.
- Wait counter (8-bit):
  - Cleared on entry to FETCH or MEM.
  - Increments on each cycle in FETCH/MEM with `mem_ack=0`.
  - If `mem_ack=0` and counter==MEM_WAIT_MAX-1, next state is FAULT.
  - An ack on the MEM_WAIT_MAX-th waiting cycle is still accepted.
- `mem_ack` outside FETCH/MEM is ignored.
- All control outputs not listed for a state are 0.
- `ir_load`, `pc_inc`, `pc_jump` are single-cycle pulses.
- `instr` is sampled only in DECODE/EXEC/MEM/WB. In those states it reflects the IR loaded in the preceding FETCH.

## Timing
- Reset:
  - Next edge → state=FETCH, `instr_count=0`, wait counter=0.
  - All control outputs, `halted` and `err` are 0 during and after the reset cycle, except `mem_req`, which rises in the first FETCH cycle.
  - Reset mid-operation (any state, including mid-handshake) aborts immediately. No `reg_we` or `mem_we` follows.
- Outputs are Moore-decoded from state and `instr`. Exceptions: `ir_load`/`pc_inc` in FETCH and state advance in FETCH/MEM are qualified by `mem_ack` (Mealy).
- Cycles per instruction with 0-wait memory: ADD 4, LW 5, SW 4, JMP 2, HALT 2. Each memory wait cycle adds 1.
- A request is held (`mem_req`, `mem_we` stable) until ack or FAULT. It is never withdrawn.

## Test plan
- Reset held 5 cycles, then released, with `mem_ack` tied 1 and instr=8'h06 (ADD rs0,rt1,rd2): state sequence 0,1,2,4,0. `reg_we=1`, `wb_sel=0` exactly in the state-4 cycle. `instr_count`=1 after WB.
- LW instr=8'h5B with `mem_ack` delayed 3 cycles in MEM: MEM lasts 4 cycles with `mem_we=0` and `alu_b_sel=1`. Next is WB with `wb_sel=1`. Total instruction is 8 cycles.
- SW instr=8'h9B, 0-wait: single MEM cycle with `mem_req=1`, `mem_we=1`. No WB; returns to FETCH. `reg_we` never asserts.
- JMP instr=8'hFE (joff=−2): `pc_jump` pulses in DECODE, count+1. instr=8'hC0: state→5, `halted=1` and stays 1 for 100 cycles despite toggling `mem_ack`.
- `mem_ack` held 0 in FETCH with MEM_WAIT_MAX=15: FAULT (state=6, `err=1`) after exactly 15 waiting cycles. A repeat run with ack on the 15th cycle proceeds to DECODE.
- Preload `instr_count` via 65536 JMP retirements: wraps to 0. Reset asserted during MEM of an SW: next state FETCH, `mem_we` never asserts again for that instruction.

Source files
------------

// File: rtl/mp_sequencer_if.sv
// rtl/mp_sequencer_if.sv - control/handshake bundle between mp_sequencer and the datapath
interface mp_sequencer_if;
  logic [7:0]  instr;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic        ir_load;
  logic        pc_inc;
  logic        pc_jump;
  logic        reg_we;
  logic        wb_sel;
  logic        alu_b_sel;
  logic [2:0]  state;
  logic        halted;
  logic        err;
  logic [15:0] instr_count;

  modport master (
    input  instr, mem_ack,
    output mem_req, mem_we, ir_load, pc_inc, pc_jump, reg_we, wb_sel, alu_b_sel,
           state, halted, err, instr_count
  );

  modport slave (
    output instr, mem_ack,
    input  mem_req, mem_we, ir_load, pc_inc, pc_jump, reg_we, wb_sel, alu_b_sel,
           state, halted, err, instr_count
  );
endinterface

// File: rtl/mp_sequencer.sv
// rtl/mp_sequencer.sv - multicycle fetch/decode/exec/mem/wb sequencer with memory stall timeout
module mp_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic          clk,
  input  logic          Reset,
  mp_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX - 1);

  state_t      r_state;
  logic [7:0]  r_wait;
  logic [15:0] r_count;

  logic [1:0]  w_op;
  logic        w_is_halt;
  logic        w_wait_expired;

  assign w_op           = bus.instr[7:6];
  assign w_is_halt      = (bus.instr == 8'hC0);
  assign w_wait_expired = (r_wait == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= S_FETCH;
      r_wait  <= 8'd0;
      r_count <= 16'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.mem_ack) begin
            r_state <= S_DECODE;
          end else if (w_wait_expired) begin
            r_state <= S_FAULT;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_DECODE: begin
          if (w_op != 2'b11) begin
            r_state <= S_EXEC;
          end else if (w_is_halt) begin
            r_state <= S_HALT;
            r_count <= r_count + 16'd1;
          end else begin
            r_state <= S_FETCH;
            r_wait  <= 8'd0;
            r_count <= r_count + 16'd1;
          end
        end
        S_EXEC: begin
          r_wait  <= 8'd0;
          r_state <= (w_op == OP_ADD) ? S_WB : S_MEM;
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            if (w_op == OP_SW) begin
              r_state <= S_FETCH;
              r_wait  <= 8'd0;
              r_count <= r_count + 16'd1;
            end else begin
              r_state <= S_WB;
            end
          end else if (w_wait_expired) begin
            r_state <= S_FAULT;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_WB: begin
          r_state <= S_FETCH;
          r_wait  <= 8'd0;
          r_count <= r_count + 16'd1;
        end
        S_HALT:  r_state <= S_HALT;
        S_FAULT: r_state <= S_FAULT;
        default: begin
          r_state <= S_FETCH;
          r_wait  <= 8'd0;
        end
      endcase
    end
  end

  // Controls are masked while Reset is high so an aborted WB/MEM never writes.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.ir_load   = 1'b0;
    bus.pc_inc    = 1'b0;
    bus.pc_jump   = 1'b0;
    bus.reg_we    = 1'b0;
    bus.wb_sel    = 1'b0;
    bus.alu_b_sel = 1'b0;
    bus.halted    = 1'b0;
    bus.err       = 1'b0;
    if (!Reset) begin
      case (r_state)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          bus.ir_load = bus.mem_ack;
          bus.pc_inc  = bus.mem_ack;
        end
        S_DECODE: bus.pc_jump = (w_op == 2'b11) && !w_is_halt;
        S_EXEC:   bus.alu_b_sel = (w_op != OP_ADD);
        S_MEM: begin
          bus.mem_req   = 1'b1;
          bus.mem_we    = (w_op == OP_SW);
          bus.alu_b_sel = 1'b1;
        end
        S_WB: begin
          bus.reg_we = 1'b1;
          bus.wb_sel = (w_op == OP_LW);
        end
        S_HALT:  bus.halted = 1'b1;
        S_FAULT: begin
          bus.halted = 1'b1;
          bus.err    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state       = r_state;
  assign bus.instr_count = r_count;

endmodule

// File: tb/tb_mp_sequencer.sv
// tb/tb_mp_sequencer.sv - directed scoreboard bench for mp_sequencer
module tb_mp_sequencer;
  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  mp_sequencer_if bus();

  mp_sequencer #(.MEM_WAIT_MAX(15)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [12:0] exp_q[$];
  string       tag_q[$];

  // {state, mem_req, mem_we, ir_load, pc_inc, pc_jump, reg_we, wb_sel, alu_b_sel, halted, err}
  logic [12:0] obs;
  assign obs = {bus.state, bus.mem_req, bus.mem_we, bus.ir_load, bus.pc_inc, bus.pc_jump,
                bus.reg_we, bus.wb_sel, bus.alu_b_sel, bus.halted, bus.err};

  function automatic logic [12:0] e_fetch(input logic ack);
    return {3'd0, 1'b1, 1'b0, ack, ack, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  endfunction
  function automatic logic [12:0] e_dec(input logic jump);
    return {3'd1, 1'b0, 1'b0, 1'b0, 1'b0, jump, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  endfunction
  function automatic logic [12:0] e_exec(input logic bsel);
    return {3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bsel, 1'b0, 1'b0};
  endfunction
  function automatic logic [12:0] e_mem(input logic we);
    return {3'd3, 1'b1, we, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  endfunction
  function automatic logic [12:0] e_wb(input logic wsel);
    return {3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, wsel, 1'b0, 1'b0, 1'b0};
  endfunction
  localparam logic [12:0] E_HALT  = {3'd5, 8'd0, 1'b1, 1'b0};
  localparam logic [12:0] E_FAULT = {3'd6, 8'd0, 1'b1, 1'b1};

  task automatic check_vec(input string tag, input logic [12:0] o, input logic [12:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] o, input logic [15:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Drive one cycle: push expectation, compare at the falling edge, leave #1 after the next rise.
  task automatic cyc(input logic ack, input logic [12:0] e, input string tag);
    bus.mem_ack = ack;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check_vec(tag_q.pop_front(), obs, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    Reset       = 1'b1;
    bus.mem_ack = 1'b1;
    bus.instr   = 8'h06;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_vec("reset_ctl", {3'd0, obs[9:0]}, 13'd0);
      check_vec("reset_state", {obs[12:10], 10'd0}, 13'd0);
      @(posedge clk);
      #1;
    end
    Reset = 1'b0;
    check16("count_reset", bus.instr_count, 16'd0);

    // ADD: 4 cycles
    cyc(1'b1, e_fetch(1'b1), "add_fetch");
    cyc(1'b1, e_dec(1'b0),   "add_decode");
    cyc(1'b1, e_exec(1'b0),  "add_exec");
    cyc(1'b1, e_wb(1'b0),    "add_wb");
    check16("count_add", bus.instr_count, 16'd1);

    // LW with 3 wait cycles in MEM: 8 cycles
    bus.instr = 8'h5B;
    cyc(1'b1, e_fetch(1'b1), "lw_fetch");
    cyc(1'b1, e_dec(1'b0),   "lw_decode");
    cyc(1'b1, e_exec(1'b1),  "lw_exec");
    for (int i = 0; i < 3; i++) cyc(1'b0, e_mem(1'b0), "lw_mem_wait");
    cyc(1'b1, e_mem(1'b0),   "lw_mem_ack");
    cyc(1'b0, e_wb(1'b1),    "lw_wb");
    check16("count_lw", bus.instr_count, 16'd2);

    // SW 0-wait
    bus.instr = 8'h9B;
    cyc(1'b1, e_fetch(1'b1), "sw_fetch");
    cyc(1'b1, e_dec(1'b0),   "sw_decode");
    cyc(1'b1, e_exec(1'b1),  "sw_exec");
    cyc(1'b1, e_mem(1'b1),   "sw_mem");
    check16("count_sw", bus.instr_count, 16'd3);

    // JMP -2
    bus.instr = 8'hFE;
    cyc(1'b1, e_fetch(1'b1), "jmp_fetch");
    cyc(1'b1, e_dec(1'b1),   "jmp_decode");
    check16("count_jmp", bus.instr_count, 16'd4);

    // Ack on the 15th waiting cycle is accepted
    for (int i = 0; i < 14; i++) cyc(1'b0, e_fetch(1'b0), "late_ack_wait");
    cyc(1'b1, e_fetch(1'b1), "late_ack_accept");
    cyc(1'b0, e_dec(1'b1),   "late_ack_decode");
    check16("count_late", bus.instr_count, 16'd5);

    // 15 waiting cycles with no ack -> FAULT
    for (int i = 0; i < 15; i++) cyc(1'b0, e_fetch(1'b0), "timeout_wait");
    for (int i = 0; i < 4; i++) cyc(i[0], E_FAULT, "fault_sticky");
    check16("count_fault", bus.instr_count, 16'd5);

    // Reset out of FAULT, then reset during MEM of a SW
    Reset = 1'b1;
    cyc(1'b0, {3'd6, 10'd0}, "fault_reset_cycle");
    Reset = 1'b0;
    bus.instr = 8'h9B;
    cyc(1'b1, e_fetch(1'b1), "swr_fetch");
    cyc(1'b1, e_dec(1'b0),   "swr_decode");
    cyc(1'b1, e_exec(1'b1),  "swr_exec");
    cyc(1'b0, e_mem(1'b1),   "swr_mem_wait");
    Reset = 1'b1;
    cyc(1'b1, {3'd3, 10'd0}, "swr_reset_cycle");
    Reset = 1'b0;
    cyc(1'b0, e_fetch(1'b0), "swr_refetch_wait");
    bus.instr = 8'hFE;
    cyc(1'b1, e_fetch(1'b1), "swr_refetch");
    cyc(1'b1, e_dec(1'b1),   "swr_jmp_decode");
    check16("count_after_abort", bus.instr_count, 16'd1);

    // Counter wrap: preload near the top, then retire two JMPs
    force dut.r_count = 16'hFFFE;
    #1;
    release dut.r_count;
    cyc(1'b1, e_fetch(1'b1), "wrap_fetch1");
    cyc(1'b1, e_dec(1'b1),   "wrap_decode1");
    check16("count_ffff", bus.instr_count, 16'hFFFF);
    cyc(1'b1, e_fetch(1'b1), "wrap_fetch2");
    cyc(1'b1, e_dec(1'b1),   "wrap_decode2");
    check16("count_wrap", bus.instr_count, 16'h0000);

    // HALT is sticky regardless of mem_ack
    bus.instr = 8'hC0;
    cyc(1'b1, e_fetch(1'b1), "halt_fetch");
    cyc(1'b1, e_dec(1'b0),   "halt_decode");
    for (int i = 0; i < 100; i++) cyc((i % 3) == 0, E_HALT, "halt_sticky");
    check16("count_halt", bus.instr_count, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
